// File: rtl/irq_evt_coalesce_if.sv
// Register-port bundle between a clk-domain bus master and irq_evt_coalesce.
interface irq_evt_coalesce_if;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;

    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output wr_en, rd_en, addr, wdata, input rdata, rvalid);
    modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/irq_evt_coalesce.sv
// Sticky, maskable event status with count/timeout coalescing into a single
// level interrupt request for irq_ctrl; causes are cleared by W1C writes.
module irq_evt_coalesce #(
    parameter int unsigned N_SRC    = 8,
    parameter int unsigned TMO_W    = 16,
    parameter logic [15:0] ID_CONST = 16'hE7C0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_SRC-1:0]     evt,
    irq_evt_coalesce_if.slave    bus,
    output logic                 irq_req
);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SUM_W  = 9;
    localparam int unsigned POP_W  = 6;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] A_ID      = 3'd0;
    localparam logic [2:0] A_STATUS  = 3'd1;
    localparam logic [2:0] A_MASK    = 3'd2;
    localparam logic [2:0] A_OVERRUN = 3'd3;
    localparam logic [2:0] A_THRESH  = 3'd4;
    localparam logic [2:0] A_TIMEOUT = 3'd5;
    localparam logic [2:0] A_EVT_CNT = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, FIRE} state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   status_q, status_d;
    logic [N_SRC-1:0]   ovr_q, ovr_d;
    logic [N_SRC-1:0]   mask_q;
    logic [CNT_W-1:0]   thresh_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_SRC-1:0]   status_w1c, ovr_w1c;
    logic [N_SRC-1:0]   accepted, armed_bits;
    logic               pend;
    logic [CNT_W-1:0]   thresh_eff;
    logic [SUM_W-1:0]   sum_acc, sum_load;
    logic [CNT_W-1:0]   cnt_acc_sat, cnt_load_sat;
    logic               tmo_hit;
    logic [DATA_W-1:0]  rd_mux;

    function automatic logic [POP_W-1:0] popcnt(input logic [N_SRC-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

    // Sticky status / overrun update; a coincident event beats the W1C clear.
    always_comb begin
        status_w1c = '0;
        ovr_w1c    = '0;
        if (bus.wr_en && (bus.addr == A_STATUS)) begin
            status_w1c = bus.wdata[N_SRC-1:0];
        end
        if (bus.wr_en && (bus.addr == A_OVERRUN)) begin
            ovr_w1c = bus.wdata[N_SRC-1:0];
        end
        status_d = (status_q & ~status_w1c) | evt;
        ovr_d    = (ovr_q & ~ovr_w1c) | (evt & status_q & ~status_w1c);
    end

    // Coalescing arithmetic shared by the FSM.
    always_comb begin
        accepted     = evt & mask_q;
        armed_bits   = status_q & mask_q;
        pend         = |armed_bits;
        thresh_eff   = (thresh_q == '0) ? CNT_W'(1) : thresh_q;
        sum_acc      = SUM_W'(cnt_q) + SUM_W'(popcnt(accepted));
        sum_load     = SUM_W'(popcnt(accepted)) + SUM_W'(popcnt(armed_bits));
        cnt_acc_sat  = (sum_acc > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_acc[CNT_W-1:0];
        cnt_load_sat = (sum_load > SUM_W'(CNT_MAX)) ? CNT_MAX : sum_load[CNT_W-1:0];
        tmo_hit      = (tmo_q != '0) && (timer_q == (tmo_q - TMO_W'(1)));
    end

    // Next-state, event count and timer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = '0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pend) begin
                    cnt_d   = cnt_load_sat;
                    state_d = (cnt_load_sat >= thresh_eff) ? FIRE : ARMED;
                end
            end
            ARMED: begin
                cnt_d = cnt_acc_sat;
                if (!pend) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if ((cnt_q >= thresh_eff) || tmo_hit) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                cnt_d = cnt_acc_sat;
                if (!pend) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if ((state_q == ARMED) && (state_d == ARMED)) begin
            timer_d = (&timer_q) ? timer_q : (timer_q + TMO_W'(1));
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (bus.addr)
            A_ID:      rd_mux = {16'h0, ID_CONST};
            A_STATUS:  rd_mux = DATA_W'(status_q);
            A_MASK:    rd_mux = DATA_W'(mask_q);
            A_OVERRUN: rd_mux = DATA_W'(ovr_q);
            A_THRESH:  rd_mux = DATA_W'(thresh_q);
            A_TIMEOUT: rd_mux = DATA_W'(tmo_q);
            A_EVT_CNT: rd_mux = DATA_W'(cnt_q);
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            irq_req <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            irq_req <= (state_d == FIRE);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_q <= '0;
            ovr_q    <= '0;
            mask_q   <= '0;
            thresh_q <= CNT_W'(1);
            tmo_q    <= '0;
        end else begin
            status_q <= status_d;
            ovr_q    <= ovr_d;
            if (bus.wr_en) begin
                unique case (bus.addr)
                    A_MASK:    mask_q   <= bus.wdata[N_SRC-1:0];
                    A_THRESH:  thresh_q <= bus.wdata[CNT_W-1:0];
                    A_TIMEOUT: tmo_q    <= bus.wdata[TMO_W-1:0];
                    default:   ;
                endcase
            end
        end
    end

    // Read data reflects pre-write register values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rvalid <= bus.rd_en;
            bus.rdata  <= bus.rd_en ? rd_mux : '0;
        end
    end
endmodule

// File: tb/tb_irq_evt_coalesce.sv
// Directed bench for irq_evt_coalesce: register map, coalescing, overrun, reset.
module tb_irq_evt_coalesce;
    logic       clk;
    logic       resetn;
    logic [7:0] evt;
    logic       irq_req;
    int         passed;
    int         total;

    irq_evt_coalesce_if bus ();

    irq_evt_coalesce #(.N_SRC(8), .TMO_W(16), .ID_CONST(16'hE7C0)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .evt     (evt),
        .bus     (bus),
        .irq_req (irq_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d, output logic v);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        tick();
        d = bus.rdata;
        v = bus.rvalid;
        bus.rd_en = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] v);
        evt = v;
        tick();
        evt = '0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        total++;
        if (irq_req !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0)
            $display("FAIL reset_outputs: got irq=%b rvalid=%b rdata=%h, expected 0/0/0", irq_req, bus.rvalid, bus.rdata);
        else passed++;
        reg_read(3'd0, d, v);
        total++;
        if (d !== 32'h0000E7C0 || v !== 1'b1)
            $display("FAIL id_read: got %h valid=%b, expected 0000e7c0 valid=1", d, v);
        else passed++;
        tick();
        total++;
        if (bus.rvalid !== 1'b0)
            $display("FAIL rvalid_pulse: got %b, expected 0", bus.rvalid);
        else passed++;
        reg_read(3'd1, d, v);
        total++;
        if (d !== 32'h0) $display("FAIL reset_status: got %h, expected 0", d); else passed++;
        reg_read(3'd4, d, v);
        total++;
        if (d !== 32'h1) $display("FAIL reset_thresh: got %h, expected 1", d); else passed++;
        reg_read(3'd7, d, v);
        total++;
        if (d !== 32'h0 || v !== 1'b1) $display("FAIL unmapped_read: got %h valid=%b, expected 0 valid=1", d, v); else passed++;
    endtask

    task automatic test_basic_latency();
        logic [31:0] d;
        logic        v;
        reg_write(3'd2, 32'h01);
        pulse(8'h01);
        total++;
        if (irq_req !== 1'b0) $display("FAIL lat_edge_k: got irq=%b, expected 0", irq_req); else passed++;
        tick();
        total++;
        if (irq_req !== 1'b1) $display("FAIL lat_edge_k1: got irq=%b, expected 1", irq_req); else passed++;
        reg_read(3'd1, d, v);
        total++;
        if (d !== 32'h1) $display("FAIL basic_status: got %h, expected 1", d); else passed++;
        reg_write(3'd1, 32'h1);
        total++;
        if (irq_req !== 1'b1) $display("FAIL clr_edge_w: got irq=%b, expected 1", irq_req); else passed++;
        tick();
        total++;
        if (irq_req !== 1'b0) $display("FAIL clr_edge_w1: got irq=%b, expected 0", irq_req); else passed++;
        reg_read(3'd6, d, v);
        total++;
        if (d !== 32'h0) $display("FAIL idle_cnt: got %h, expected 0", d); else passed++;
    endtask

    task automatic test_count_thresh();
        logic [31:0] d;
        logic        v;
        reg_write(3'd2, 32'hFF);
        reg_write(3'd4, 32'h4);
        reg_write(3'd5, 32'h0);
        pulse(8'h01); tick();
        pulse(8'h02); tick();
        pulse(8'h04); tick();
        reg_read(3'd6, d, v);
        total++;
        if (d !== 32'h3 || irq_req !== 1'b0)
            $display("FAIL cnt_three: got cnt=%h irq=%b, expected 3/0", d, irq_req);
        else passed++;
        pulse(8'h08);
        total++;
        if (irq_req !== 1'b0) $display("FAIL cnt_four_edge: got irq=%b, expected 0", irq_req); else passed++;
        tick();
        total++;
        if (irq_req !== 1'b1) $display("FAIL cnt_four_fire: got irq=%b, expected 1", irq_req); else passed++;
        reg_read(3'd6, d, v);
        total++;
        if (d !== 32'h4) $display("FAIL cnt_four: got %h, expected 4", d); else passed++;
        reg_write(3'd1, 32'hFF);
        tick();
        total++;
        if (irq_req !== 1'b0) $display("FAIL cnt_clear: got irq=%b, expected 0", irq_req); else passed++;
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        reg_write(3'd4, 32'h8);
        reg_write(3'd5, 32'd100);
        pulse(8'h20);
        tick();
        for (int i = 0; i < 99; i++) begin
            tick();
            if (irq_req !== 1'b0) early++;
        end
        total++;
        if (early != 0) $display("FAIL tmo_early: got %0d early cycles, expected 0", early); else passed++;
        tick();
        total++;
        if (irq_req !== 1'b1) $display("FAIL tmo_fire: got irq=%b, expected 1", irq_req); else passed++;
        reg_write(3'd1, 32'hFF);
        reg_write(3'd5, 32'h0);
        total++;
        if (irq_req !== 1'b0) $display("FAIL tmo_clear: got irq=%b, expected 0", irq_req); else passed++;
    endtask

    task automatic test_overrun();
        logic [31:0] d;
        logic        v;
        pulse(8'h04);
        pulse(8'h04);
        reg_read(3'd3, d, v);
        total++;
        if (d !== 32'h4) $display("FAIL ovr_set: got %h, expected 4", d); else passed++;
        evt = 8'h04;
        reg_write(3'd1, 32'h4);
        evt = '0;
        reg_read(3'd1, d, v);
        total++;
        if (d !== 32'h4) $display("FAIL evt_beats_w1c: got %h, expected 4", d); else passed++;
        reg_read(3'd3, d, v);
        total++;
        if (d !== 32'h4) $display("FAIL ovr_unchanged: got %h, expected 4", d); else passed++;
        evt = 8'h04;
        reg_write(3'd3, 32'h4);
        evt = '0;
        reg_read(3'd3, d, v);
        total++;
        if (d !== 32'h4) $display("FAIL ovr_evt_beats_w1c: got %h, expected 4", d); else passed++;
        reg_write(3'd3, 32'hFF);
        reg_write(3'd1, 32'hFF);
        reg_read(3'd3, d, v);
        total++;
        if (d !== 32'h0) $display("FAIL ovr_w1c: got %h, expected 0", d); else passed++;
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        logic        v;
        reg_write(3'd4, 32'hFF);
        evt = 8'hFF;
        repeat (40) tick();
        evt = '0;
        tick();
        reg_read(3'd6, d, v);
        total++;
        if (d !== 32'hFF || irq_req !== 1'b1)
            $display("FAIL cnt_saturate: got cnt=%h irq=%b, expected ff/1", d, irq_req);
        else passed++;
        reg_write(3'd1, 32'hFF);
        reg_write(3'd3, 32'hFF);
        total++;
        if (irq_req !== 1'b0) $display("FAIL sat_clear: got irq=%b, expected 0", irq_req); else passed++;
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] d;
        logic        v;
        bus.rd_en = 1'b1;
        bus.wr_en = 1'b1;
        bus.addr  = 3'd4;
        bus.wdata = 32'h0;
        tick();
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        total++;
        if (bus.rdata !== 32'hFF) $display("FAIL rw_prewrite: got %h, expected ff", bus.rdata); else passed++;
        reg_read(3'd4, d, v);
        total++;
        if (d !== 32'h0) $display("FAIL thresh_written: got %h, expected 0", d); else passed++;
        reg_write(3'd0, 32'h12345678);
        reg_read(3'd0, d, v);
        total++;
        if (d !== 32'h0000E7C0) $display("FAIL id_ro: got %h, expected 0000e7c0", d); else passed++;
        pulse(8'h01);
        tick();
        total++;
        if (irq_req !== 1'b1) $display("FAIL thresh_zero: got irq=%b, expected 1", irq_req); else passed++;
        reg_write(3'd1, 32'hFF);
        tick();
    endtask

    task automatic test_mask_and_reset();
        logic [31:0] d;
        logic        v;
        reg_write(3'd4, 32'h1);
        reg_write(3'd2, 32'h7F);
        pulse(8'h80);
        tick();
        reg_read(3'd1, d, v);
        total++;
        if (d !== 32'h80 || irq_req !== 1'b0)
            $display("FAIL masked_evt: got status=%h irq=%b, expected 80/0", d, irq_req);
        else passed++;
        reg_write(3'd2, 32'hFF);
        tick();
        total++;
        if (irq_req !== 1'b1) $display("FAIL unmask_fire: got irq=%b, expected 1", irq_req); else passed++;
        reg_write(3'd2, 32'h00);
        total++;
        if (irq_req !== 1'b1) $display("FAIL mask_off_edge: got irq=%b, expected 1", irq_req); else passed++;
        tick();
        total++;
        if (irq_req !== 1'b0) $display("FAIL mask_off_drop: got irq=%b, expected 0", irq_req); else passed++;
        reg_read(3'd1, d, v);
        total++;
        if (d !== 32'h80) $display("FAIL status_retained: got %h, expected 80", d); else passed++;
        reg_write(3'd2, 32'hFF);
        tick();
        reg_read(3'd0, d, v);
        resetn = 1'b0;
        #1;
        total++;
        if (irq_req !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0)
            $display("FAIL async_reset: got irq=%b rvalid=%b rdata=%h, expected 0/0/0", irq_req, bus.rvalid, bus.rdata);
        else passed++;
        tick();
        resetn = 1'b1;
        tick();
        reg_read(3'd1, d, v);
        total++;
        if (d !== 32'h0) $display("FAIL post_reset_status: got %h, expected 0", d); else passed++;
        reg_read(3'd2, d, v);
        total++;
        if (d !== 32'h0) $display("FAIL post_reset_mask: got %h, expected 0", d); else passed++;
        reg_read(3'd4, d, v);
        total++;
        if (d !== 32'h1) $display("FAIL post_reset_thresh: got %h, expected 1", d); else passed++;
        total++;
        if (irq_req !== 1'b0) $display("FAIL post_reset_irq: got irq=%b, expected 0", irq_req); else passed++;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        resetn    = 1'b0;
        evt       = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        test_reset();
        test_basic_latency();
        test_count_thresh();
        test_timeout();
        test_overrun();
        test_saturation();
        test_rw_same_cycle();
        test_mask_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/irq_evt_coalesce.md
Name: irq_evt_coalesce

Overview:
- Upstream event aggregator for irq_ctrl.
- Latches single-cycle event pulses from correlator sources (channel epochs, dump-ready, overflow) into a sticky, maskable status register.
- Applies count/timeout coalescing and drives one level request, irq_req, into the irq_ctrl source input.
- Software clears the causes with W1C writes through a simple clk-domain register port.

Parameters:
- N_SRC, 8, number of event inputs (1..32).
- TMO_W, 16, width of the timeout counter and TIMEOUT register.
- ID_CONST, 16'hE7C0, value returned in ID[15:0].

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- evt  in  N_SRC  event pulses, one clk wide each, any combination per cycle.
- wr_en  in  1  register write strobe.
- rd_en  in  1  register read strobe.
- addr  in  3  word offset.
- wdata  in  32  write data.
- rdata  out  32  read data.
- rvalid  out  1  read data valid.
- irq_req  out  1  coalesced interrupt request, level, to irq_ctrl.

Behaviour:
- Register map (word offsets):
  - 0 ID, RO: {16'h0, ID_CONST}.
  - 1 STATUS, W1C: [N_SRC-1:0] sticky pending.
  - 2 MASK, RW: 1 = source enabled; reset 0.
  - 3 OVERRUN, W1C: set when evt[i]=1 while STATUS[i] is already 1.
  - 4 THRESH, RW: [7:0]; reset 1.
  - 5 TIMEOUT, RW: [TMO_W-1:0]; reset 0 = timeout disabled.
  - 6 EVT_CNT, RO: [7:0].
  - 7: reads 0.
  - Unused bits read 0; writes to RO or unmapped offsets are ignored.
- Reset values: all registers as listed, state IDLE, irq_req=0, rdata=0, rvalid=0.
- STATUS[i] sets on the edge sampling evt[i]=1, regardless of MASK.
  - evt[i] and a W1C of bit i in the same cycle: the event wins, bit stays 1, no overrun.
  - Same rule applies to OVERRUN.
- Accepted events: evt & MASK in a sampling cycle.
  - EVT_CNT += popcount(accepted), saturating at 255, in states ARMED and FIRE.
  - On the IDLE->ARMED/FIRE transition edge, EVT_CNT loads popcount(accepted events of that cycle plus those that caused the arm).
  - EVT_CNT clears to 0 on entering IDLE.
- pend = |(STATUS & MASK), evaluated from registered values.
- FSM:
  - IDLE: pend=1 -> FIRE if EVT_CNT_next >= THRESH, else ARMED.
  - ARMED: timer counts from 0 each clk.
    - pend=0 (cleared or masked) -> IDLE.
    - EVT_CNT >= THRESH -> FIRE.
    - TIMEOUT!=0 and timer == TIMEOUT-1 -> FIRE.
  - FIRE: irq_req=1; pend=0 -> IDLE.
- THRESH=0 is treated as 1.
- irq_req is registered, = (state==FIRE).
- Latency with THRESH=1: evt on edge k -> irq_req=1 after edge k+1.
- Clearing the last masked pending bit at edge w -> irq_req=0 after edge w+1.
- Writing MASK to 0 in FIRE drops irq_req one cycle later; STATUS bits are retained.
- Reads: rd_en at edge r -> rdata and rvalid=1 after edge r; rvalid is a single-cycle pulse.
  - Read and write to the same offset in one cycle: rdata returns the pre-write value.
- The timer saturates and does not wrap. It resets to 0 in IDLE.
- Async reset mid-operation returns everything to reset values immediately; no events are remembered.

Test Plan:
- Read offset 0 after reset -> rdata=32'h0000E7C0, rvalid one cycle; irq_req=0, STATUS=0.
- MASK=8'h01, THRESH=1, pulse evt[0] -> STATUS=1, irq_req=1 two edges after the pulse; W1C STATUS=1 -> irq_req=0 one cycle later, state IDLE.
- MASK=8'hFF, THRESH=4, TIMEOUT=0, pulse evt[0], evt[1], evt[2] on separate cycles -> irq_req stays 0, EVT_CNT=3; evt[3] -> EVT_CNT=4, irq_req=1.
- THRESH=8, TIMEOUT=100, one evt[5] -> irq_req rises exactly 100 clk after entering ARMED, +1 registered.
- evt[2] twice without clear -> OVERRUN[2]=1; evt[2] coincident with W1C STATUS[2] -> STATUS[2] stays 1, OVERRUN unchanged.
- evt[7] with MASK[7]=0 -> STATUS[7]=1, irq_req=0; set MASK[7]=1 -> irq_req=1; assert resetn low mid-FIRE -> irq_req=0 and all registers at reset values immediately.
